ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_rx_sync.sv | 35 +++
 rtl/ws2812_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 serial receiver: data width, default
// 100 MHz timing constants and the receiver state encoding.
package ws2812_pkg;

    localparam int W_DATA = 24;

    // Nominal WS2812 timing in 100 MHz clk cycles.
    localparam int WS_T0H        = 40;    // nominal high time of a 0 bit
    localparam int WS_T1H        = 80;    // nominal high time of a 1 bit
    localparam int WS_T_THRESH   = 60;    // 0/1 decision point
    localparam int WS_T_HIGH_MAX = 150;   // longest legal high pulse
    localparam int WS_T_RESET    = 5000;  // 50 us low = frame latch

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,   // waiting for a full reset-length low before trusting the line
        ST_IDLE = 2'd1,   // between frames, waiting for the first rising edge
        ST_HIGH = 2'd2,   // measuring a high pulse
        ST_LOW  = 2'd3    // measuring the low gap after a bit
    } ws2812_rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line, followed by one
// history flop so rising and falling edges of the synchronized level can be
// flagged for a single cycle.
module ws2812_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic line,
    output logic rise,
    output logic fall
);

    // sh_q[0], sh_q[1]: synchronizer; sh_q[2]: previous synchronized level
    logic [2:0] sh_q;
    logic [2:0] sh_d;

    // Shift the raw line into the synchronizer chain
    always_comb begin
        sh_d = {sh_q[1:0], din};
    end

    // Synchronizer and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign line = sh_q[1];
    assign rise =  sh_q[1] & ~sh_q[2];
    assign fall = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes high-pulse widths into bits, assembles
// 24-bit pixel words (first bit in the MSB), numbers pixels within a frame
// and flags frame latches and protocol errors.
// Optional build macro WS2812_RX_ERRCNT_EN enables the saturating 8-bit
// error counter on err_cnt; without it err_cnt reads 0.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_THRESH   = WS_T_THRESH,
    parameter int T_HIGH_MAX = WS_T_HIGH_MAX,
    parameter int T_RESET    = WS_T_RESET,
    parameter int W_ADDR     = 6,
    parameter int N_LEDS     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic              pix_valid,
    output logic [W_DATA-1:0] pix_data,
    output logic [W_ADDR-1:0] pix_addr,
    output logic              frame_done,
    output logic              err,
    output logic [7:0]        err_cnt
);

    // Duration counters saturate at T_RESET, so they never wrap.
    localparam int CW = $clog2(T_RESET + 1);
    // One extra address bit so the counter can park at N_LEDS.
    localparam int AW = W_ADDR + 1;
    localparam int BW = $clog2(W_DATA);

    localparam logic [CW-1:0] T_RESET_C  = CW'(T_RESET);
    localparam logic [CW-1:0] T_THRESH_C = CW'(T_THRESH);
    localparam logic [CW-1:0] T_HMAX_C   = CW'(T_HIGH_MAX);
    localparam logic [AW-1:0] N_LEDS_C   = AW'(N_LEDS);
    localparam logic [BW-1:0] LAST_BIT_C = BW'(W_DATA - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= T_RESET_C) begin
            return T_RESET_C;
        end
        return v + 1'b1;
    endfunction

    logic line;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .line  (line),
        .rise  (rise),
        .fall  (fall)
    );

    ws2812_rx_state_t  state_q,      state_d;
    logic [CW-1:0]     hcnt_q,       hcnt_d;
    logic [CW-1:0]     lcnt_q,       lcnt_d;
    logic [BW-1:0]     bit_cnt_q,    bit_cnt_d;
    // Bits received so far; the final bit is appended directly at completion.
    logic [W_DATA-2:0] shift_q,      shift_d;
    logic [W_DATA-1:0] pix_data_q,   pix_data_d;
    logic              pix_valid_q,  pix_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q,        err_d;
    logic [AW-1:0]     addr_q,       addr_d;
    logic              addr_inc_q,   addr_inc_d;
    logic              ovf_q,        ovf_d;

    logic              bit_v;
    logic              addr_full;
    logic [CW-1:0]     lcnt_inc;

    assign addr_full = (addr_q == N_LEDS_C);
    assign lcnt_inc  = sat_inc(lcnt_q);

    // Next-state, counter, word assembly and pulse generation
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        addr_d       = addr_q;
        addr_inc_d   = 1'b0;
        ovf_d        = ovf_q;
        bit_v        = (hcnt_q >= T_THRESH_C);

        // Address advances the cycle after a pixel is delivered.
        if (addr_inc_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                if (line) begin
                    lcnt_d = '0;
                end else if (lcnt_inc == T_RESET_C) begin
                    lcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end

            ST_IDLE: begin
                if (rise) begin
                    hcnt_d  = CW'(1);
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (hcnt_q > T_HMAX_C) begin
                    // Over-long pulse: drop the word and resynchronize.
                    err_d     = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    lcnt_d    = '0;
                    state_d   = ST_SYNC;
                end else if (fall) begin
                    shift_d = {shift_q[W_DATA-3:0], bit_v};
                    lcnt_d  = '0;
                    state_d = ST_LOW;
                    if (bit_cnt_q == LAST_BIT_C) begin
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        if (!addr_full) begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = {shift_q, bit_v};
                            addr_inc_d  = 1'b1;
                        end else if (!ovf_q) begin
                            // Only the first surplus pixel of a frame is flagged.
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                end
            end

            ST_LOW: begin
                if (rise) begin
                    hcnt_d  = CW'(1);
                    state_d = ST_HIGH;
                end else if (lcnt_inc == T_RESET_C) begin
                    frame_done_d = 1'b1;
                    addr_d       = '0;
                    ovf_d        = 1'b0;
                    lcnt_d       = '0;
                    state_d      = ST_IDLE;
                    if (bit_cnt_q != '0) begin
                        // Latch arrived mid-word: the partial word is lost.
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State, counters, word buffer and output pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            addr_inc_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            addr_inc_q   <= addr_inc_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef WS2812_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    // Saturating count of error pulses, stepping on the same edge as err
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_addr   = addr_q[W_ADDR-1:0];
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx. Timing parameters are scaled down (1/5 of the
// 100 MHz values, shorter latch, 8 LEDs) so every scenario stays short.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int TT  = 12;   // threshold
    localparam int THM = 30;   // longest legal high
    localparam int TR  = 400;  // latch low length
    localparam int WA  = 3;
    localparam int NL  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din;
    logic          pix_valid;
    logic [23:0]   pix_data;
    logic [WA-1:0] pix_addr;
    logic          frame_done;
    logic          err;
    logic [7:0]    err_cnt;

    ws2812_rx #(
        .T_THRESH   (TT),
        .T_HIGH_MAX (THM),
        .T_RESET    (TR),
        .W_ADDR     (WA),
        .N_LEDS     (NL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .frame_done (frame_done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [23:0] got_data[$];
    int          got_addr[$];
    int          got_cyc[$];
    int          n_err  = 0;
    int          n_fd   = 0;
    int          n_both = 0;

    always @(negedge clk) begin
        if (pix_valid) begin
            got_data.push_back(pix_data);
            got_addr.push_back(int'(pix_addr));
            got_cyc.push_back(cyc);
        end
        if (err) n_err++;
        if (frame_done) n_fd++;
        if (err && frame_done) n_both++;
    end

    int checks = 0;
    int errors = 0;
    int exp_err_total = 0;
    int last_fall_cyc = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int exp_err_cnt();
`ifdef WS2812_RX_ERRCNT_EN
        return (exp_err_total > 255) ? 255 : exp_err_total;
`else
        return 0;
`endif
    endfunction

    // All drive tasks start and end on a falling clk edge.
    task automatic send_pulse(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        last_fall_cyc = cyc;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int h;
        h = b ? int'($urandom_range(TT + 2, THM - 6)) : int'($urandom_range(TT - 6, TT - 2));
        send_pulse(h, int'($urandom_range(8, 18)));
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic hold_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic latch();
        hold_low(TR + 10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %0b want 0", pix_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %0b want 0", frame_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
        checks++; if (pix_data !== 24'h0) begin errors++; $display("FAIL rst_pix_data: got %06h want 0", pix_data); end
        checks++; if (pix_addr !== '0) begin errors++; $display("FAIL rst_pix_addr: got %0d want 0", pix_addr); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        exp_err_total = 0;
    endtask

    task automatic test_single();
        int base, f0, e0;
        latch();
        base = got_data.size(); f0 = n_fd; e0 = n_err;
        send_word(24'h0F1F01);
        latch();
        checks++; if (got_data.size() - base !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_data.size() - base); end
        if (got_data.size() > base) begin
            checks++; if (got_data[base] !== 24'h0F1F01) begin errors++; $display("FAIL single_data: got %06h want 0f1f01", got_data[base]); end
            checks++; if (got_addr[base] !== 0) begin errors++; $display("FAIL single_addr: got %0d want 0", got_addr[base]); end
            checks++; if (got_cyc[base] !== last_fall_cyc + 3) begin errors++; $display("FAIL single_latency: got %0d want 3", got_cyc[base] - last_fall_cyc); end
        end
        checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL single_frame_done: got %0d want 1", n_fd - f0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", n_err - e0); end
        checks++; if (pix_data !== 24'h0F1F01) begin errors++; $display("FAIL single_hold: got %06h want 0f1f01", pix_data); end
        checks++; if (pix_addr !== '0) begin errors++; $display("FAIL single_addr_after: got %0d want 0", pix_addr); end
    endtask

    task automatic test_multi();
        logic [23:0] w[4];
        int          a[4];
        int base, f0, e0;
        w[0] = 24'h010F01; w[1] = 24'h0F0F01; w[2] = 24'h01012F; w[3] = 24'h0F0F0F;
        a[0] = 0; a[1] = 1; a[2] = 2; a[3] = 0;
        base = got_data.size(); f0 = n_fd; e0 = n_err;
        for (int i = 0; i < 3; i++) send_word(w[i]);
        latch();
        send_word(w[3]);
        latch();
        checks++; if (got_data.size() - base !== 4) begin errors++; $display("FAIL multi_count: got %0d want 4", got_data.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= got_data.size() || got_data[base + i] !== w[i] || got_addr[base + i] !== a[i]) begin
                errors++;
                $display("FAIL multi_pixel%0d: got %06h@%0d want %06h@%0d", i,
                         (base + i < got_data.size()) ? got_data[base + i] : 24'hx,
                         (base + i < got_addr.size()) ? got_addr[base + i] : -1, w[i], a[i]);
            end
        end
        checks++; if (n_fd - f0 !== 2) begin errors++; $display("FAIL multi_frame_done: got %0d want 2", n_fd - f0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL multi_err: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_thresholds();
        int          lens[3];
        logic [23:0] exp_w;
        int base, h;
        lens[0] = TT - 1; lens[1] = TT; lens[2] = THM;
        base = got_data.size();
        exp_w = '0;
        for (int i = 0; i < 24; i++) begin
            h = lens[$urandom_range(0, 2)];
            exp_w = {exp_w[22:0], (h >= TT) ? 1'b1 : 1'b0};
            send_pulse(h, int'($urandom_range(8, 18)));
        end
        latch();
        checks++;
        if (got_data.size() - base !== 1 || got_data[base] !== exp_w) begin
            errors++;
            $display("FAIL thresh_word: got %0d words first %06h want %06h",
                     got_data.size() - base, (got_data.size() > base) ? got_data[base] : 24'hx, exp_w);
        end
    endtask

    task automatic test_long_high();
        logic [23:0] w;
        int base, f0, e0;
        base = got_data.size(); f0 = n_fd; e0 = n_err;
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        send_pulse(200, 20);
        exp_err_total++;
        send_word(24'($urandom));
        hold_low(20);
        checks++; if (got_data.size() - base !== 0) begin errors++; $display("FAIL long_no_pixel: got %0d want 0", got_data.size() - base); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL long_err: got %0d want 1", n_err - e0); end
        checks++; if (err_cnt !== 8'(exp_err_cnt())) begin errors++; $display("FAIL long_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt()); end
        latch();
        checks++; if (n_fd - f0 !== 0) begin errors++; $display("FAIL long_no_latch: got %0d want 0", n_fd - f0); end
        w = 24'($urandom);
        send_word(w);
        latch();
        checks++;
        if (got_data.size() - base !== 1 || got_data[base] !== w || got_addr[base] !== 0) begin
            errors++;
            $display("FAIL long_recover: got %0d words want 1 word %06h at 0", got_data.size() - base, w);
        end
        checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL long_recover_latch: got %0d want 1", n_fd - f0); end
    endtask

    task automatic test_overflow();
        logic [23:0] w[$];
        int base, f0, e0;
        base = got_data.size(); f0 = n_fd; e0 = n_err;
        for (int i = 0; i < NL + 2; i++) w.push_back(24'($urandom));
        foreach (w[i]) send_word(w[i]);
        latch();
        exp_err_total++;
        checks++; if (got_data.size() - base !== NL) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_data.size() - base, NL); end
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (base + i >= got_data.size() || got_data[base + i] !== w[i] || got_addr[base + i] !== i) begin
                errors++;
                $display("FAIL ovf_pixel%0d: want %06h@%0d", i, w[i], i);
            end
        end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL ovf_err: got %0d want 1", n_err - e0); end
        checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL ovf_frame_done: got %0d want 1", n_fd - f0); end
        checks++; if (pix_addr !== '0) begin errors++; $display("FAIL ovf_addr_after: got %0d want 0", pix_addr); end
    endtask

    task automatic test_partial();
        int base, f0, e0, b0;
        base = got_data.size(); f0 = n_fd; e0 = n_err; b0 = n_both;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        latch();
        exp_err_total++;
        checks++; if (got_data.size() - base !== 0) begin errors++; $display("FAIL partial_no_pixel: got %0d want 0", got_data.size() - base); end
        checks++; if (n_both - b0 !== 1) begin errors++; $display("FAIL partial_same_cycle: got %0d want 1", n_both - b0); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL partial_err: got %0d want 1", n_err - e0); end
        checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL partial_frame_done: got %0d want 1", n_fd - f0); end
        checks++; if (err_cnt !== 8'(exp_err_cnt())) begin errors++; $display("FAIL partial_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt()); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] w;
        int base, f0;
        base = got_data.size(); f0 = n_fd;
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        din = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rmid_err_cnt: got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        exp_err_total = 0;
        hold_low(3);
        send_word(24'($urandom));
        hold_low(20);
        checks++; if (got_data.size() - base !== 0) begin errors++; $display("FAIL rmid_no_pixel: got %0d want 0", got_data.size() - base); end
        latch();
        checks++; if (n_fd - f0 !== 0) begin errors++; $display("FAIL rmid_no_latch: got %0d want 0", n_fd - f0); end
        w = 24'($urandom);
        send_word(w);
        latch();
        checks++;
        if (got_data.size() - base !== 1 || got_data[base] !== w || got_addr[base] !== 0) begin
            errors++;
            $display("FAIL rmid_recover: got %0d words want 1 word %06h at 0", got_data.size() - base, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] w[$];
        int base, f0, n;
        for (int f = 0; f < 3; f++) begin
            base = got_data.size(); f0 = n_fd;
            n = int'($urandom_range(1, NL));
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(24'($urandom));
            foreach (w[i]) send_word(w[i]);
            latch();
            checks++; if (got_data.size() - base !== n) begin errors++; $display("FAIL b2b%0d_count: got %0d want %0d", f, got_data.size() - base, n); end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (base + i >= got_data.size() || got_data[base + i] !== w[i] || got_addr[base + i] !== i) begin
                    errors++;
                    $display("FAIL b2b%0d_pixel%0d: want %06h@%0d", f, i, w[i], i);
                end
            end
            checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL b2b%0d_frame_done: got %0d want 1", f, n_fd - f0); end
        end
        checks++; if (err_cnt !== 8'(exp_err_cnt())) begin errors++; $display("FAIL b2b_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt()); end
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_thresholds();
        test_long_high();
        test_overflow();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
